// File: rtl/fpga_link_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fpga_link_pkg                                                    |
// | Purpose  : Shared types and constants for the FPGA link receiver.           |
// |            ST_ABORT exists only when FPGA_RX_TIMEOUT_EN is defined.          |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package fpga_link_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RECEIVE = 3'd3,
    ST_NEXT    = 3'd4,
    ST_PROCESS = 3'd5,
    ST_END     = 3'd6
`ifdef FPGA_RX_TIMEOUT_EN
    , ST_ABORT = 3'd7
`endif
  } state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fpga_rx_fifo                                                     |
// | Purpose  : Synchronous first-word-fall-through FIFO with wrap-bit pointers. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module fpga_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, rptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              w_wr_en, w_rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the slot being written, so a full FIFO can still accept a push.
  assign w_rd_en = pop_i & ~empty_o;
  assign w_wr_en = push_i & (~full_o | w_rd_en);

  assign head_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_wr_en) wptr_q <= wptr_q + 1'b1;
      if (w_rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/fpga_link_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fpga_link_receiver                                               |
// | Purpose  : Bit-handshake link receiver with word assembly, FIFO and errors. |
// |            Define FPGA_RX_TIMEOUT_EN to enable the WAIT timeout / ABORT.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module fpga_link_receiver
  import fpga_link_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
`ifdef FPGA_RX_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              send,
  input  logic              finish,
  input  logic              data_in,
  input  logic              processed,
  output logic              acknowledge,
  output logic              received,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  word_count,
  output logic              frame_error,
  output logic              overflow
);

  localparam int BIT_W = cnt_width(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-2:0]   sreg_q, sreg_d;
  logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                ferr_q, ferr_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   w_word;
  logic                w_push, w_full, w_empty;

`ifdef FPGA_RX_TIMEOUT_EN
  localparam int TMO_W = cnt_width(TIMEOUT);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign w_word = {sreg_q, data_in};

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    wcnt_d   = wcnt_q;
    ferr_d   = ferr_q;
    ovf_d    = 1'b0;
    w_push   = 1'b0;
`ifdef FPGA_RX_TIMEOUT_EN
    tmo_d    = '0;
`endif
    case (state_q)
      ST_IDLE: if (send) state_d = ST_START;
      ST_START: begin
        sreg_d   = '0;
        bitcnt_d = '0;
        wcnt_d   = '0;
        ferr_d   = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef FPGA_RX_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
`endif
        if (send)        state_d = ST_RECEIVE;
        else if (finish) state_d = ST_PROCESS;
`ifdef FPGA_RX_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) state_d = ST_ABORT;
`endif
      end
      ST_RECEIVE: begin
        sreg_d  = w_word[DATA_W-2:0];
        state_d = ST_NEXT;
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_d = '0;
          if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
          // Full with no pop in the same cycle: the word is lost.
          if (w_full && !(word_ready && !w_empty)) begin
            ovf_d  = 1'b1;
            ferr_d = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      ST_NEXT: state_d = ST_WAIT;
      ST_PROCESS: begin
        if (bitcnt_q != '0) begin
          ferr_d   = 1'b1;
          bitcnt_d = '0;
          sreg_d   = '0;
        end
        if (processed) state_d = ST_END;
      end
      ST_END: state_d = ST_IDLE;
`ifdef FPGA_RX_TIMEOUT_EN
      ST_ABORT: begin
        ferr_d   = 1'b1;
        bitcnt_d = '0;
        sreg_d   = '0;
        state_d  = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      wcnt_q   <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef FPGA_RX_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      wcnt_q   <= wcnt_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
`ifdef FPGA_RX_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  fpga_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (w_word),
    .pop_i       (word_ready),
    .head_o      (word_out),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign acknowledge = (state_q == ST_START) || (state_q == ST_NEXT) || (state_q == ST_END);
  assign received    = (state_q == ST_PROCESS);
  assign word_valid  = ~w_empty;
  assign word_count  = wcnt_q;
  assign frame_error = ferr_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_link_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_fpga_link_receiver                                            |
// | Purpose  : Directed scoreboard bench for fpga_link_receiver (DEPTH=2).      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_fpga_link_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0, finish = 1'b0, data_in = 1'b0, processed = 1'b0;
  logic       word_ready = 1'b0;
  logic       acknowledge, received, word_valid, frame_error, overflow;
  logic [7:0] word_out, word_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ack_cnt  = 0;
  int         ovf_cnt  = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  fpga_link_receiver #(
    .DATA_W (8),
    .DEPTH  (2),
    .CNT_W  (8)
`ifdef FPGA_RX_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .send        (send),
    .finish      (finish),
    .data_in     (data_in),
    .processed   (processed),
    .acknowledge (acknowledge),
    .received    (received),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_count  (word_count),
    .frame_error (frame_error),
    .overflow    (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted word must match the oldest expected one.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (acknowledge) ack_cnt++;
        if (overflow) ovf_cnt++;
        if (word_valid && word_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h expected none", word_out);
          end else begin
            e = exp_q.pop_front();
            chk("word_out", {24'd0, word_out}, {24'd0, e});
          end
        end
      end
    end
  end

  task automatic wait_ack(input string nm);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!acknowledge && n < 40);
    if (!acknowledge) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: acknowledge not seen in %0d cycles, expected it", nm, n);
    end
    @(posedge clock); #1;
  endtask

  task automatic open_frame();
    send = 1'b1;
    wait_ack("start_ack");
    send = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    send    = 1'b1;
    wait_ack("bit_ack");
    send    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic close_frame(input logic exp_err, input string nm);
    int n = 0;
    finish = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!received && n < 40);
    if (!received) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_process: received low after %0d cycles, expected 1", nm, n);
    end
    @(posedge clock); #1;
    finish = 1'b0;
    @(negedge clock);
    chk({nm, "_frame_error"}, {31'd0, frame_error}, {31'd0, exp_err});
    @(posedge clock); #1;
    processed = 1'b1;
    wait_ack("end_ack");
    processed = 1'b0;
  endtask

  initial begin
    int a0, o0;
    // Reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ack", {31'd0, acknowledge}, 0);
    chk("rst_valid", {31'd0, word_valid}, 0);
    chk("rst_word_out", {24'd0, word_out}, 0);
    @(posedge clock); #1;

    // Single word 0xA5: 10 acknowledge pulses
    word_ready = 1'b1;
    a0 = ack_cnt;
    exp_q.push_back(8'hA5);
    open_frame();
    send_word(8'hA5);
    close_frame(1'b0, "a5");
    chk("a5_word_count", {24'd0, word_count}, 1);
    chk("a5_ack_pulses", ack_cnt - a0, 10);

    // Two buffered words, popped in order afterwards
    word_ready = 1'b0;
    open_frame();
    send_word(8'h3C);
    chk("latency_valid", {31'd0, word_valid}, 1);
    send_word(8'hC3);
    close_frame(1'b0, "two");
    chk("two_word_count", {24'd0, word_count}, 2);
    chk("two_head", {24'd0, word_out}, 32'h3C);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    word_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 word_ready = 1'b0;
    @(negedge clock);
    chk("two_drained", {31'd0, word_valid}, 0);
    @(posedge clock); #1;

    // 11 bits: one word, three partial bits discarded with error
    word_ready = 1'b1;
    exp_q.push_back(8'h5A);
    open_frame();
    send_word(8'h5A);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    close_frame(1'b1, "partial");
    chk("partial_word_count", {24'd0, word_count}, 1);

    // Overflow on the third word with DEPTH=2
    word_ready = 1'b0;
    o0 = ovf_cnt;
    open_frame();
    chk("start_clears_error", {31'd0, frame_error}, 0);
    send_word(8'h11);
    send_word(8'h22);
    chk("pre_ovf_error", {31'd0, frame_error}, 0);
    send_word(8'h33);
    chk("ovf_pulses", ovf_cnt - o0, 1);
    chk("ovf_error", {31'd0, frame_error}, 1);
    chk("ovf_head", {24'd0, word_out}, 32'h11);
    close_frame(1'b1, "ovf");
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    word_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("ovf_drained", {31'd0, word_valid}, 0);
    @(posedge clock); #1;

    // send and finish together: bit taken, frame continues
    word_ready = 1'b0;
    open_frame();
    data_in = 1'b1;
    send    = 1'b1;
    finish  = 1'b1;
    wait_ack("both_ack");
    send   = 1'b0;
    finish = 1'b0;
    chk("both_not_process", {31'd0, received}, 0);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    send_bit(1'b1);
    chk("both_head", {24'd0, word_out}, 32'h81);
    chk("both_word_count", {24'd0, word_count}, 1);

    // Reset mid-word
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_ack", {31'd0, acknowledge}, 0);
    chk("mid_rst_received", {31'd0, received}, 0);
    chk("mid_rst_valid", {31'd0, word_valid}, 0);
    chk("mid_rst_word_out", {24'd0, word_out}, 0);
    chk("mid_rst_word_count", {24'd0, word_count}, 0);
    chk("mid_rst_error", {31'd0, frame_error}, 0);
    chk("mid_rst_overflow", {31'd0, overflow}, 0);
    @(posedge clock); #1;

`ifdef FPGA_RX_TIMEOUT_EN
    // Stall in WAIT: 16 WAIT cycles, ABORT, then IDLE with error set
    begin
      int n = 0;
      open_frame();
      a0 = ack_cnt;
      do begin
        @(negedge clock);
        n++;
      end while (!frame_error && n < 40);
      chk("tmo_cycles", n, 18);
      chk("tmo_no_ack", ack_cnt - a0, 0);
      chk("tmo_error", {31'd0, frame_error}, 1);
      @(posedge clock); #1;
    end
`endif

    repeat (4) @(posedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fpga_link_receiver.md
# fpga_link_receiver

Parametrised successor of the single-bit FPGA-to-FPGA receiver controller. It runs the same send/acknowledge bit handshake as before and adds three things: it assembles serial bits into DATA_W-bit words, buffers them in a DEPTH-entry FIFO with a valid/ready output stream, and reports frame-level errors. It sits between the inter-FPGA link pins (send, finish, data_in, acknowledge) and the local consumer logic.

## Interface
Parameters:
- DATA_W, 8: bits per word, ≥2.
- DEPTH, 4: word FIFO entries, power of two, ≥2.
- CNT_W, 8: width of the frame word counter.
- TIMEOUT, 1024: idle cycles tolerated in WAIT (timeout build only).

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- send, input, 1: transmitter bit request; data_in is valid while send is high.
- finish, input, 1: transmitter end-of-frame request.
- data_in, input, 1: serial data bit.
- processed, input, 1: consumer has finished frame post-processing.
- acknowledge, output, 1: handshake acknowledge to the transmitter.
- received, output, 1: high while in PROCESS.
- word_out, output, DATA_W: FIFO head word (first-word fall-through).
- word_valid, output, 1: FIFO not empty.
- word_ready, input, 1: consumer pops the head when word_valid & word_ready.
- word_count, output, CNT_W: words completed in the current frame; saturates at all-ones.
- frame_error, output, 1: sticky error flag; cleared on START or reset.
- overflow, output, 1: one-cycle pulse when a completed word is dropped.

## Operation
- State machine: IDLE, START, WAIT, RECEIVE, NEXT, PROCESS, END, plus ABORT in the timeout build. Any illegal encoding goes to IDLE on the next edge.
- IDLE: send → START. Otherwise stay.
- START: acknowledge=1. Clear bit counter, word_count, and frame_error. → WAIT.
- WAIT: send → RECEIVE. Else finish → PROCESS. Else stay. If send and finish are both high, send wins.
- RECEIVE: shift the register, MSB first: sreg ← {sreg[DATA_W-2:0], data_in}. Increment the bit counter. → NEXT.
  - If this shift completes word DATA_W, push the word to the FIFO on the same edge, increment word_count, and reset the bit counter.
  - If the FIFO is full and there is no simultaneous pop, drop the word, pulse overflow, and set frame_error.
- NEXT: acknowledge=1. → WAIT.
- PROCESS: received=1. If the bit counter ≠ 0 (partial word), set frame_error and discard the partial bits. processed → END; otherwise stay.
- END: acknowledge=1. → IDLE.
- ABORT: set frame_error, discard the partial word, hold acknowledge=0. → IDLE.
- FIFO: words already pushed stay readable across frames. Push and pop in the same cycle are both accepted, so a full FIFO with a simultaneous pop does not overflow.

## Timing
- Reset values, applied at the next edge: state IDLE; acknowledge 0; received 0; word_valid 0; word_out 0; word_count 0; frame_error 0; overflow 0. Reset empties the FIFO and clears sreg and the bit counter.
- Reset overrides every transition, including mid-frame. The partial word and all buffered words are lost.
- Outputs are decoded from registered state. acknowledge is high for exactly one cycle per START, NEXT, and END.
- Minimum cost per bit is 3 cycles: WAIT, RECEIVE, NEXT.
- Word latency: word_valid rises in the cycle after the RECEIVE edge that completed the word.
- The transmitter must hold data_in stable from send rising until it sees acknowledge. It must drop send before the next WAIT is sampled, or a further bit is taken.

## Configuration
- FPGA_RX_TIMEOUT_EN defined:
  - A counter runs while in WAIT and resets on leaving WAIT.
  - If it reaches TIMEOUT with neither send nor finish high, → ABORT.
- Not defined: no counter and no ABORT state. WAIT waits indefinitely.

## Structure
- Package fpga_link_pkg holds:
  - the state enum type;
  - default DATA_W, DEPTH, and CNT_W constants;
  - a clog2-based width helper for the counters.
- Sub-module fpga_rx_fifo: synchronous first-word-fall-through FIFO, parametrised by DATA_W and DEPTH. It has full/empty flags and uses wrap-around pointers with an extra MSB.
- The FSM, shift register, and counters live in the top module.

## Test plan
- DATA_W=8, frame of bits 1,0,1,0,0,1,0,1 then finish and processed → word_out=0xA5, word_count=1, frame_error=0. acknowledge pulses 10 times (START, 8×NEXT, END).
- Two words 0x3C and 0xC3 with word_ready=0 → FIFO holds both, word_valid=1. Popping with word_ready=1 yields 0x3C then 0xC3, then word_valid=0.
- 11 bits then finish → one word pushed, word_count=1, frame_error=1 in PROCESS. The 3 partial bits never appear on word_out.
- DEPTH=2, word_ready=0, three words sent → third completion pulses overflow and sets frame_error. The FIFO still holds the first two words.
- send and finish high together in WAIT → RECEIVE is entered, not PROCESS. Reset asserted mid-word → next cycle IDLE with all outputs at reset values.
- FPGA_RX_TIMEOUT_EN, TIMEOUT=16, stall in WAIT → ABORT after 16 cycles, then IDLE with frame_error=1.
